// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes and processor status values.
// Imported by fetch, decode_writeBack and memory_stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

endpackage

// File: rtl/memory_stage_data_mem.sv
// Byte-addressable data memory: synchronous little-endian 8-byte write,
// combinational 8-byte read, and full-width range check on the address.
module data_mem #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic              wr_allow,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES - 8);

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] idx;
  logic          we;

  // Compare the full address so wrap-around values never alias into the array
  assign err = (rd || wr) && (addr > LIMIT);
  assign idx = addr[AW-1:0];
  assign we  = wr && !err && wr_allow;

  always_comb begin
    rdata = '0;
    if (rd && !err) begin
      for (int i = 0; i < 8; i++) begin
        rdata[8*i +: 8] = mem[idx + AW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < MEM_BYTES; j++) begin
        mem[j] <= 8'h00;
      end
    end else if (we) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// SEQ Y86-64 memory stage: access decode, data memory, processor status
// and the sticky halt that freezes further stores.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [2:0]  stat,
  output logic        halted
);

  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       wdata;
  logic              rd;
  logic              wr;
  logic              wr_allow;
  logic [2:0]        cur_stat;
  logic [2:0]        halt_stat;

  always_comb begin
    rd       = 1'b0;
    wr       = 1'b0;
    mem_addr = valE[ADDR_W-1:0];
    wdata    = valA;
    case (icode)
      IRMMOVQ, IPUSHQ: wr = 1'b1;
      ICALL: begin
        wr    = 1'b1;
        wdata = valP;
      end
      IMRMOVQ: rd = 1'b1;
      IRET, IPOPQ: begin
        rd       = 1'b1;
        mem_addr = valA[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    if (imem_error || dmem_error) cur_stat = SADR;
    else if (!instr_valid)        cur_stat = SINS;
    else if (icode == IHALT)      cur_stat = SHLT;
    else                          cur_stat = SAOK;
  end

  assign stat     = halted ? halt_stat : cur_stat;
  assign wr_allow = !halted && !reset && (stat == SAOK);

  data_mem #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_dmem (
    .clk      (clk),
    .reset    (reset),
    .addr     (mem_addr),
    .rd       (rd),
    .wr       (wr),
    .wr_allow (wr_allow),
    .wdata    (wdata),
    .rdata    (valM),
    .err      (dmem_error)
  );

  // Halt latches the first non-AOK status and holds it until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      halted    <= 1'b0;
      halt_stat <= SAOK;
    end else if (!halted && cur_stat != SAOK) begin
      halted    <= 1'b1;
      halt_stat <= cur_stat;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed Y86 memory-stage vectors with
// hand-computed expectations, checked by an independent negedge monitor.
module tb_memory_stage;
  import y86_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        instr_valid, imem_error;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;
  logic        halted;

  memory_stage #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .icode       (icode),
    .valA        (valA),
    .valE        (valE),
    .valP        (valP),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .valM        (valM),
    .dmem_error  (dmem_error),
    .stat        (stat),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] vm;
    logic        de;
    logic [2:0]  st;
    logic        h;
  } exp_t;

  exp_t exp_q[$];
  logic chk_en;
  int   n_checks;
  int   n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".valM"},       valM,       e.vm);
        check({e.name, ".dmem_error"}, 64'(dmem_error), 64'(e.de));
        check({e.name, ".stat"},       64'(stat),  64'(e.st));
        check({e.name, ".halted"},     64'(halted), 64'(e.h));
      end
    end
  end

  task automatic step(input string name, input logic [3:0] ic, input logic [63:0] a,
                      input logic [63:0] e, input logic [63:0] p, input logic iv,
                      input logic ime, input logic rst, input logic do_chk,
                      input logic [63:0] x_vm, input logic x_de, input logic [2:0] x_st,
                      input logic x_h);
    exp_t x;
    @(posedge clk);
    #1;
    icode = ic; valA = a; valE = e; valP = p;
    instr_valid = iv; imem_error = ime; reset = rst;
    if (do_chk) begin
      x.name = name; x.vm = x_vm; x.de = x_de; x.st = x_st; x.h = x_h;
      exp_q.push_back(x);
    end
    chk_en = do_chk;
  endtask

  task automatic do_reset();
    step("rst", INOP, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, SAOK, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; chk_en = 1'b0;
    reset = 1'b1; icode = INOP; valA = '0; valE = '0; valP = '0;
    instr_valid = 1'b1; imem_error = 1'b0;

    // Reset state and store/load round trip
    step("reset_state", INOP, 0, 0, 0, 1, 0, 0, 1, 64'd0, 0, SAOK, 0);
    step("rmmovq_40", IRMMOVQ, 64'h0123456789ABCDEF, 64'h40, 0, 1, 0, 0, 1, 64'd0, 0, SAOK, 0);
    step("mrmovq_40", IMRMOVQ, 0, 64'h40, 0, 1, 0, 0, 1, 64'h0123456789ABCDEF, 0, SAOK, 0);
    step("mrmovq_39", IMRMOVQ, 0, 64'h39, 0, 1, 0, 0, 1, 64'hEF00000000000000, 0, SAOK, 0);
    step("mrmovq_41", IMRMOVQ, 0, 64'h41, 0, 1, 0, 0, 1, 64'h000123456789ABCD, 0, SAOK, 0);

    // Stack pair: call/ret and pushq/popq
    step("call", ICALL, 0, 64'h1F8, 64'h2A, 1, 0, 0, 1, 64'd0, 0, SAOK, 0);
    step("ret", IRET, 64'h1F8, 0, 0, 1, 0, 0, 1, 64'h2A, 0, SAOK, 0);
    step("pushq", IPUSHQ, 64'd525, 64'h1F0, 0, 1, 0, 0, 1, 64'd0, 0, SAOK, 0);
    step("popq", IPOPQ, 64'h1F0, 0, 0, 1, 0, 0, 1, 64'd525, 0, SAOK, 0);

    // Invalid instruction suppresses the store and latches INS
    step("ins_store", IRMMOVQ, 64'h77, 64'h10, 0, 0, 0, 0, 1, 64'd0, 0, SINS, 0);
    step("ins_read", IMRMOVQ, 0, 64'h10, 0, 1, 0, 0, 1, 64'd0, 0, SINS, 1);
    do_reset();
    step("adr_over_ins", INOP, 0, 0, 0, 0, 1, 0, 1, 64'd0, 0, SADR, 0);
    step("adr_latched", INOP, 0, 0, 0, 1, 0, 0, 1, 64'd0, 0, SADR, 1);
    do_reset();

    // Address fault at the top of memory
    step("fill_1016", IRMMOVQ, 64'h1111111111111111, 64'd1016, 0, 1, 0, 0, 1, 64'd0, 0, SAOK, 0);
    step("fault_1017", IRMMOVQ, 64'd999, 64'd1017, 0, 1, 0, 0, 1, 64'd0, 1, SADR, 0);
    step("read_1016", IMRMOVQ, 0, 64'd1016, 0, 1, 0, 0, 1, 64'h1111111111111111, 0, SADR, 1);
    do_reset();
    step("wrap_read", IMRMOVQ, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 0, 1, 64'd0, 1, SADR, 0);
    do_reset();

    // Halt stickiness
    step("halt", IHALT, 0, 0, 0, 1, 0, 0, 1, 64'd0, 0, SHLT, 0);
    step("halted_store", IRMMOVQ, 64'd300, 64'h80, 0, 1, 0, 0, 1, 64'd0, 0, SHLT, 1);
    step("halted_read", IMRMOVQ, 0, 64'h80, 0, 1, 0, 0, 1, 64'd0, 0, SHLT, 1);
    do_reset();
    step("post_rst_80", IMRMOVQ, 0, 64'h80, 0, 1, 0, 0, 1, 64'd0, 0, SAOK, 0);

    // Reset during a store discards it
    step("store_dead", IRMMOVQ, 64'hDEAD, 64'h20, 0, 1, 0, 0, 1, 64'd0, 0, SAOK, 0);
    step("read_dead", IMRMOVQ, 0, 64'h20, 0, 1, 0, 0, 1, 64'hDEAD, 0, SAOK, 0);
    step("rst_beef", IRMMOVQ, 64'hBEEF, 64'h20, 0, 1, 0, 1, 0, 64'd0, 0, SAOK, 0);
    step("read_after", IMRMOVQ, 0, 64'h20, 0, 1, 0, 0, 1, 64'd0, 0, SAOK, 0);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
